// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-size codes, the
// sequencer state encoding and the alignment/legality check.
package dmem_pkg;

    localparam logic [1:0] MODE_B = 2'b00;
    localparam logic [1:0] MODE_H = 2'b01;
    localparam logic [1:0] MODE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    // Halves need an even address, words a 4-byte aligned one; code 11 never reaches memory.
    function automatic logic is_legal(input logic [1:0] mode, input logic [1:0] addr_lsb);
        case (mode)
            MODE_B:  is_legal = 1'b1;
            MODE_H:  is_legal = ~addr_lsb[0];
            MODE_W:  is_legal = (addr_lsb == 2'b00);
            default: is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the
// requester that did not win last time (ptr holds the last winner).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       winner,
    output logic       any
);

    always_comb begin
        any = |req;
        if (req == 2'b11) begin
            winner = ~ptr;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one combinational-read data memory between the core load/store path
// (r0) and the debug/loader port (r1) with a registered req/gnt/rvalid handshake.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_W     = 32,
    parameter int MODE_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [MODE_W-1:0]     r0_mode,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_W-1:0]     r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_W-1:0]     r0_rdata,
    output logic                  r0_err,

    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [MODE_W-1:0]     r1_mode,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_W-1:0]     r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_W-1:0]     r1_rdata,
    output logic                  r1_err,

    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [MODE_W-1:0]     mem_mode,
    output logic [DATA_W-1:0]     mem_d_in,
    input  logic [DATA_W-1:0]     mem_d_out,

    output logic                  busy
);

    state_t                  state_q, state_d;
    logic                    rr_ptr_q, rr_ptr_d;
    logic                    cmd_id_q, cmd_id_d;
    logic                    cmd_we_q, cmd_we_d;
    logic [MODE_W-1:0]       cmd_mode_q, cmd_mode_d;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]       cmd_wdata_q, cmd_wdata_d;
    logic [1:0]              gnt_q, gnt_d;
    logic [1:0]              rvalid_q, rvalid_d;
    logic [1:0]              err_q, err_d;
    logic [DATA_W-1:0]       rdata0_q, rdata0_d;
    logic [DATA_W-1:0]       rdata1_q, rdata1_d;

    logic                    arb_winner;
    logic                    arb_any;
    logic                    cmd_legal;
    logic [DATA_W-1:0]       resp_data;

    rr_arb2 u_rr_arb2 (
        .req    ({r1_req, r0_req}),
        .ptr    (rr_ptr_q),
        .winner (arb_winner),
        .any    (arb_any)
    );

    assign cmd_legal = is_legal(cmd_mode_q[1:0], cmd_addr_q[1:0]);
    assign resp_data = cmd_legal ? mem_d_out : '0;

    // The memory side is a pure function of the command registers, so the
    // request bus is free to change once gnt has been seen.
    assign mem_wr_en   = (state_q == ST_ACCESS) && cmd_we_q && cmd_legal;
    assign mem_wr_addr = cmd_addr_q;
    assign mem_rd_addr = cmd_addr_q;
    assign mem_mode    = cmd_mode_q;
    assign mem_d_in    = cmd_wdata_q;
    assign busy        = (state_q != ST_IDLE);

    assign r0_gnt    = gnt_q[0];
    assign r1_gnt    = gnt_q[1];
    assign r0_rvalid = rvalid_q[0];
    assign r1_rvalid = rvalid_q[1];
    assign r0_err    = err_q[0];
    assign r1_err    = err_q[1];
    assign r0_rdata  = rdata0_q;
    assign r1_rdata  = rdata1_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cmd_id_d    = cmd_id_q;
        cmd_we_d    = cmd_we_q;
        cmd_mode_d  = cmd_mode_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        err_d       = err_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        case (state_q)
            ST_ACCESS: begin
                state_d = ST_RESP;
                // Reads and rejected accesses answer; legal writes complete silently.
                if (!cmd_legal || !cmd_we_q) begin
                    rvalid_d[cmd_id_q] = 1'b1;
                    err_d[cmd_id_q]    = ~cmd_legal;
                    if (cmd_id_q) begin
                        rdata1_d = resp_data;
                    end else begin
                        rdata0_d = resp_data;
                    end
                end
            end
            default: begin
                // IDLE and RESP both arbitrate, giving one access every two cycles.
                if (arb_any) begin
                    state_d     = ST_ACCESS;
                    rr_ptr_d    = arb_winner;
                    cmd_id_d    = arb_winner;
                    cmd_we_d    = arb_winner ? r1_we    : r0_we;
                    cmd_mode_d  = arb_winner ? r1_mode  : r0_mode;
                    cmd_addr_d  = arb_winner ? r1_addr  : r0_addr;
                    cmd_wdata_d = arb_winner ? r1_wdata : r0_wdata;
                    gnt_d[arb_winner] = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 1'b1;
            cmd_id_q    <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_mode_q  <= '0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            err_q       <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cmd_id_q    <= cmd_id_d;
            cmd_we_q    <= cmd_we_d;
            cmd_mode_q  <= cmd_mode_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a byte-array d_mem, a transaction-level model that
// predicts every cycle's outputs, and directed scenarios with literal expectations.
module tb_dmem_arbiter;

    localparam int NEXP = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [1:0]  r0_mode, r1_mode;
    logic [7:0]  r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_addr, mem_rd_addr;
    logic [1:0]  mem_mode;
    logic [31:0] mem_d_in, mem_d_out;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_mode(r0_mode), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
        .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_mode(r1_mode), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
        .r1_rdata(r1_rdata), .r1_err(r1_err),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
        .mem_mode(mem_mode), .mem_d_in(mem_d_in), .mem_d_out(mem_d_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // d_mem stand-in: little-endian bytes, combinational right-aligned read.
    logic [7:0] dmem [256];
    logic [7:0] ra1, ra2, ra3;
    assign ra1 = mem_rd_addr + 8'd1;
    assign ra2 = mem_rd_addr + 8'd2;
    assign ra3 = mem_rd_addr + 8'd3;

    always_comb begin
        case (mem_mode)
            2'b00:   mem_d_out = {24'h0, dmem[mem_rd_addr]};
            2'b01:   mem_d_out = {16'h0, dmem[ra1], dmem[mem_rd_addr]};
            default: mem_d_out = {dmem[ra3], dmem[ra2], dmem[ra1], dmem[mem_rd_addr]};
        endcase
    end

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 8'(i) ^ 8'h5A;
        forever begin
            @(posedge clk);
            if (mem_wr_en) begin
                dmem[mem_wr_addr] <= mem_d_in[7:0];
                if (mem_mode != 2'b00) dmem[mem_wr_addr + 8'd1] <= mem_d_in[15:8];
                if (mem_mode == 2'b10) begin
                    dmem[mem_wr_addr + 8'd2] <= mem_d_in[23:16];
                    dmem[mem_wr_addr + 8'd3] <= mem_d_in[31:24];
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transactions against a golden byte memory, expectations per cycle.
    logic [7:0] gold [256];
    bit   [1:0]  exp_gnt   [NEXP];
    bit   [1:0]  exp_rv    [NEXP];
    bit          exp_errv  [NEXP];
    bit   [31:0] exp_rdv   [NEXP];
    bit          exp_wr    [NEXP];
    bit   [7:0]  exp_waddr [NEXP];
    bit   [1:0]  exp_wmode [NEXP];
    bit   [31:0] exp_wdata [NEXP];
    bit          exp_busy  [NEXP];
    int cyc = 0;

    function automatic logic model_legal(input logic [1:0] m, input logic [7:0] a);
        if (m == 2'b11) return 1'b0;
        if (m == 2'b10) return (a % 4) == 0;
        if (m == 2'b01) return (a % 2) == 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] gold_read(input logic [7:0] a, input logic [1:0] m);
        logic [31:0] v;
        int nbytes;
        v = 32'h0;
        nbytes = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
        for (int b = 0; b < nbytes; b++) v = v | (32'(gold[8'(a + b)]) << (8 * b));
        return v;
    endfunction

    initial begin
        int next_free;
        int last_win;
        for (int i = 0; i < 256; i++) gold[i] = 8'(i) ^ 8'h5A;
        next_free = 0;
        last_win  = 1;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int k = 0; k <= 3; k++) begin
                    exp_gnt[(cyc + k) % NEXP]  = 2'b00;
                    exp_rv[(cyc + k) % NEXP]   = 2'b00;
                    exp_wr[(cyc + k) % NEXP]   = 1'b0;
                    exp_busy[(cyc + k) % NEXP] = 1'b0;
                end
                next_free = 0;
                last_win  = 1;
            end else if (cyc >= next_free && (r0_req || r1_req)) begin
                int w, j1, j2, nbytes;
                logic we, legal;
                logic [1:0] m;
                logic [7:0] a;
                logic [31:0] wd;
                w  = (r0_req && r1_req) ? 1 - last_win : (r1_req ? 1 : 0);
                we = w ? r1_we : r0_we;
                m  = w ? r1_mode : r0_mode;
                a  = w ? r1_addr : r0_addr;
                wd = w ? r1_wdata : r0_wdata;
                legal = model_legal(m, a);
                j1 = (cyc + 1) % NEXP;
                j2 = (cyc + 2) % NEXP;
                exp_gnt[j1]  = (w == 1) ? 2'b10 : 2'b01;
                exp_busy[j1] = 1'b1;
                exp_busy[j2] = 1'b1;
                if (legal && we) begin
                    exp_wr[j1]    = 1'b1;
                    exp_waddr[j1] = a;
                    exp_wmode[j1] = m;
                    exp_wdata[j1] = wd;
                    nbytes = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
                    for (int b = 0; b < nbytes; b++) gold[8'(a + b)] = wd[8*b +: 8];
                end else begin
                    exp_rv[j2]   = (w == 1) ? 2'b10 : 2'b01;
                    exp_errv[j2] = ~legal;
                    exp_rdv[j2]  = legal ? gold_read(a, m) : 32'h0;
                end
                next_free = cyc + 2;
                last_win  = w;
            end
            cyc++;
        end
    end

    // Every cycle: DUT outputs against the model's expectation for that cycle.
    always @(negedge clk) begin
        int j;
        j = cyc % NEXP;
        if (rst) begin
            checkOutput("rst_gnt",     {r1_gnt, r0_gnt}, 32'h0);
            checkOutput("rst_rvalid",  {r1_rvalid, r0_rvalid}, 32'h0);
            checkOutput("rst_wr_en",   mem_wr_en, 32'h0);
            checkOutput("rst_busy",    busy, 32'h0);
            checkOutput("rst_wr_addr", mem_wr_addr, 32'h0);
            checkOutput("rst_d_in",    mem_d_in, 32'h0);
        end else begin
            checkOutput("gnt",    {r1_gnt, r0_gnt}, exp_gnt[j]);
            checkOutput("rvalid", {r1_rvalid, r0_rvalid}, exp_rv[j]);
            checkOutput("busy",   busy, exp_busy[j]);
            checkOutput("wr_en",  mem_wr_en, exp_wr[j]);
            if (exp_rv[j][0]) begin
                checkOutput("r0_err",   r0_err, exp_errv[j]);
                checkOutput("r0_rdata", r0_rdata, exp_rdv[j]);
            end
            if (exp_rv[j][1]) begin
                checkOutput("r1_err",   r1_err, exp_errv[j]);
                checkOutput("r1_rdata", r1_rdata, exp_rdv[j]);
            end
            if (exp_wr[j]) begin
                checkOutput("wr_addr", mem_wr_addr, exp_waddr[j]);
                checkOutput("wr_mode", mem_mode, exp_wmode[j]);
                checkOutput("d_in",    mem_d_in, exp_wdata[j]);
            end
        end
    end

    task automatic applyStimulus(input int p, input logic we, input logic [1:0] m,
                                 input logic [7:0] a, input logic [31:0] wd);
        if (p == 0) begin
            r0_req = 1'b1; r0_we = we; r0_mode = m; r0_addr = a; r0_wdata = wd;
        end else begin
            r1_req = 1'b1; r1_we = we; r1_mode = m; r1_addr = a; r1_wdata = wd;
        end
    endtask

    task automatic dropReq(input int p);
        if (p == 0) r0_req = 1'b0;
        else        r1_req = 1'b0;
    endtask

    // One transaction from idle with hand-computed T+1 / T+2 / T+3 expectations.
    task automatic runTxn(input int p, input logic we, input logic [1:0] m, input logic [7:0] a,
                          input logic [31:0] wd, input logic e_rv, input logic e_err,
                          input logic [31:0] e_rdata);
        applyStimulus(p, we, m, a, wd);
        @(posedge clk); #1;
        checkOutput("txn_gnt", (p == 0) ? r0_gnt : r1_gnt, 32'h1);
        checkOutput("txn_wr_en_access", mem_wr_en, {31'h0, we & ~e_err});
        dropReq(p);
        @(posedge clk); #1;
        checkOutput("txn_rvalid", (p == 0) ? r0_rvalid : r1_rvalid, {31'h0, e_rv});
        checkOutput("txn_wr_en_resp", mem_wr_en, 32'h0);
        if (e_rv) begin
            checkOutput("txn_err",   (p == 0) ? r0_err : r1_err, {31'h0, e_err});
            checkOutput("txn_rdata", (p == 0) ? r0_rdata : r1_rdata, e_rdata);
        end
        @(posedge clk); #1;
        checkOutput("txn_busy_after", busy, 32'h0);
    endtask

    initial begin
        int order[$];
        int gcyc[$];
        int n0, n1, c;
        rst = 1'b1;
        r0_req = 0; r0_we = 0; r0_mode = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_mode = 0; r1_addr = 0; r1_wdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_busy",     busy, 32'h0);
        checkOutput("reset_r0_rdata", r0_rdata, 32'h0);
        checkOutput("reset_mem_addr", mem_rd_addr, 32'h0);
        checkOutput("reset_mem_mode", mem_mode, 32'h0);

        $display("[TB] r0 word write then read at 0x80");
        runTxn(0, 1'b1, 2'b10, 8'h80, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        runTxn(0, 1'b0, 2'b10, 8'h80, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);

        $display("[TB] r1 byte write 0xAA to 0x91, word read of 0x90");
        runTxn(1, 1'b1, 2'b00, 8'h91, 32'h000000AA, 1'b0, 1'b0, 32'h0);
        runTxn(1, 1'b0, 2'b10, 8'h90, 32'h0, 1'b1, 1'b0, 32'hC9C8AACA);
        checkOutput("byte_lane", {24'h0, r1_rdata[15:8]}, 32'h000000AA);

        $display("[TB] both requesters contend for six transactions");
        n0 = 0; n1 = 0; c = 0;
        applyStimulus(0, 1'b0, 2'b10, 8'h80, 32'h0);
        applyStimulus(1, 1'b0, 2'b10, 8'hA0, 32'h0);
        for (int k = 0; k < 40 && order.size() < 6; k++) begin
            @(posedge clk); #1;
            c++;
            if (r0_gnt) begin
                order.push_back(0); gcyc.push_back(c); n0++;
                if (n0 < 3) applyStimulus(0, 1'b0, 2'b10, 8'h80 + 8'(4 * n0), 32'h0);
                else        dropReq(0);
            end
            if (r1_gnt) begin
                order.push_back(1); gcyc.push_back(c); n1++;
                if (n1 < 3) applyStimulus(1, 1'b0, 2'b10, 8'hA0 + 8'(4 * n1), 32'h0);
                else        dropReq(1);
            end
        end
        dropReq(0); dropReq(1);
        checkOutput("grant_count", order.size(), 32'd6);
        for (int i = 0; i < order.size(); i++) begin
            checkOutput("grant_order", order[i], i % 2);
            if (i > 0) checkOutput("grant_spacing", gcyc[i] - gcyc[i-1], 32'd2);
        end
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("contend_busy_after", busy, 32'h0);

        $display("[TB] misaligned word read and illegal-mode write");
        runTxn(0, 1'b0, 2'b10, 8'h82, 32'h0, 1'b1, 1'b1, 32'h0);
        runTxn(0, 1'b1, 2'b11, 8'h84, 32'h01020304, 1'b1, 1'b1, 32'h0);

        $display("[TB] reset during a write access");
        applyStimulus(0, 1'b1, 2'b10, 8'hC0, 32'h12345678);
        @(posedge clk); #1;
        checkOutput("abort_gnt", r0_gnt, 32'h1);
        checkOutput("abort_wr_en_before", mem_wr_en, 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_wr_en", mem_wr_en, 32'h0);
        checkOutput("abort_gnt_cleared", r0_gnt, 32'h0);
        checkOutput("abort_busy", busy, 32'h0);
        dropReq(0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("abort_no_gnt", r0_gnt, 32'h0);
            checkOutput("abort_no_rvalid", r0_rvalid, 32'h0);
        end
        runTxn(0, 1'b0, 2'b10, 8'h80, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);

        $display("[TB] r1 back-to-back reads of 0x80 and 0x84");
        applyStimulus(1, 1'b0, 2'b10, 8'h80, 32'h0);
        @(posedge clk); #1;
        checkOutput("b2b_gnt0", r1_gnt, 32'h1);
        applyStimulus(1, 1'b0, 2'b10, 8'h84, 32'h0);
        @(posedge clk); #1;
        checkOutput("b2b_rvalid0", r1_rvalid, 32'h1);
        checkOutput("b2b_rdata0", r1_rdata, 32'hDEADBEEF);
        checkOutput("b2b_busy_mid", busy, 32'h1);
        @(posedge clk); #1;
        checkOutput("b2b_gnt1", r1_gnt, 32'h1);
        dropReq(1);
        @(posedge clk); #1;
        checkOutput("b2b_rvalid1", r1_rvalid, 32'h1);
        checkOutput("b2b_rdata1", r1_rdata, 32'hDDDCDFDE);
        @(posedge clk); #1;
        checkOutput("b2b_busy_after", busy, 32'h0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not reach its end");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer that shares the single data memory (d_mem) between two requesters.
- Requester 0 is the rv32i core's load/store path. Requester 1 is a debug/loader port that preloads data images and reads signature words while the core runs.
- Grants are round-robin with a registered req/gnt/rvalid handshake. Misaligned or illegal-mode accesses are rejected with an error pulse and never reach the memory.

Parameters:
- ADDR_WIDTH, 8, byte address width (matches d_mem).
- DATA_W, 32, data width.
- MODE_W, 2, access-size field width (00 byte, 01 half, 10 word, 11 illegal).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- r0_req  in  1  requester 0 access request.
- r0_we  in  1  1 = write, 0 = read.
- r0_mode  in  MODE_W  access size.
- r0_addr  in  ADDR_WIDTH  byte address.
- r0_wdata  in  DATA_W  write data, right-aligned.
- r0_gnt  out  1  one-cycle pulse: request accepted.
- r0_rvalid  out  1  one-cycle pulse: response valid (reads and errors).
- r0_rdata  out  DATA_W  read data.
- r0_err  out  1  qualifies rvalid: misaligned or illegal mode.
- r1_*  same set as r0_* for requester 1.
- mem_wr_en  out  1  to d_mem wr_en.
- mem_wr_addr  out  ADDR_WIDTH  to d_mem wr_addr.
- mem_rd_addr  out  ADDR_WIDTH  to d_mem rd_addr.
- mem_mode  out  MODE_W  to d_mem mode.
- mem_d_in  out  DATA_W  to d_mem d_in.
- mem_d_out  in  DATA_W  from d_mem d_out. Combinational read of mem_rd_addr.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: all outputs 0. State = IDLE. rr_ptr = 1, so r0 wins the first tie. Command registers are cleared.
- States: IDLE, ACCESS, RESP.
- IDLE, or RESP with a request pending (cycle T):
  - Pick the winner. If only one requester asserts req, it wins. On a tie, the requester not equal to rr_ptr wins.
  - Latch winner id, we, mode, addr and wdata into command registers.
  - Set rr_ptr to the winner. Go to ACCESS. rN_gnt pulses high in T+1.
- ACCESS (T+1):
  - mem_* outputs are driven only from the command registers. mem_wr_en = cmd_we AND legal; mem_rd_addr = mem_wr_addr = cmd_addr.
  - For a read, capture mem_d_out into the rdata register. Go to RESP.
- RESP (T+2):
  - For reads and errors: winner's rvalid pulses and rdata/err hold valid. Writes produce no rvalid.
  - rdata holds its value until the next read response.
  - Arbitrate again in this same cycle. If no request is pending, go to IDLE.
  - Sustained throughput: one access per 2 cycles.
- Outside ACCESS, mem_wr_en = 0. mem addresses and mode hold their last values.
- Legality:
  - Word requires addr[1:0] = 00. Half requires addr[0] = 0. Byte is always legal. Mode 11 is illegal.
  - An illegal access still gets gnt, suppresses mem_wr_en, and returns rvalid=1, err=1, rdata=0. This applies to writes too.
- Handshake: the requester holds req and its command stable until gnt. It may change them in the cycle after gnt. The bus is not sampled during ACCESS.
- Read data: right-aligned exactly as d_mem returns it. No extension is done here.
- Fairness: with both requesters asserting continuously, grants alternate r0, r1, r0, ... and neither waits more than one transaction.
- Reset mid-operation: asynchronous return to IDLE. mem_wr_en drops immediately, and an in-flight write may or may not complete. No gnt or rvalid is issued for the aborted access.
- No address wrap: legal word accesses top out at 0xFC.

Decomposition:
- Package dmem_pkg holds:
  - mode constants MODE_B = 2'b00, MODE_H = 2'b01, MODE_W = 2'b10.
  - state encoding ST_IDLE, ST_ACCESS, ST_RESP.
  - function is_legal(mode, addr).
- Sub-module rr_arb2: combinational 2-way round-robin picker. Inputs req[1:0] and ptr; outputs winner and any.
- Datapath, FSM and command registers stay in dmem_arbiter.

Test Plan:
- Reset, then r0 writes word 0xDEADBEEF to 0x80. Expect r0_gnt at T+1, mem_wr_en=1 only at T+1, no rvalid. A following r0 read of 0x80 returns rvalid with rdata=0xDEADBEEF at T+2.
- r0 and r1 both request continuously for 6 transactions. Expect grant order r0, r1, r0, r1, r0, r1, with gnt pulses spaced exactly 2 cycles apart.
- r1 writes byte 0xAA to 0x91, then reads word 0x90. Expect the byte lane to merge per d_mem: rdata[15:8] = 0xAA.
- r0 reads word at 0x82 and separately issues mode 11 at 0x84. Both give gnt, rvalid=1, err=1, rdata=0, and mem_wr_en stays 0 throughout.
- Assert rst during ACCESS of a write. All outputs go to 0 immediately, no gnt/rvalid follows, and after release the next r0 request is served normally.
- r1 only requesting while r0 is idle: back-to-back r1 reads of 0x80 and 0x84 complete in 4 cycles, and busy drops the cycle after the last RESP.
